// File: rtl/jkseq_if.sv
// Sample/result bundle for the JK counter sequence checker.
// The stimulus side drives en/q/clr_cnt; the checker drives all status and counters.
interface jkseq_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             en;
  logic [2:0]       q;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic             illegal;
  logic [2:0]       pos;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] per_cnt;

  modport master (
    output en, q, clr_cnt,
    input  locked, err, illegal, pos, err_cnt, per_cnt
  );

  modport slave (
    input  en, q, clr_cnt,
    output locked, err, illegal, pos, err_cnt, per_cnt
  );
endinterface

// File: rtl/jkseq_checker.sv
// Receive-side monitor for the 6-state JK counter 000->011->101->110->010->001->000:
// acquires lock, flags mismatches and illegal codes, counts errors and full periods.
module jkseq_checker #(
  parameter int unsigned LOCK_N   = 3,
  parameter int unsigned UNLOCK_N = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic    clk,
  input  logic    rst,
  jkseq_if.slave  bus
);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  localparam logic [2:0]       LockN   = 3'(LOCK_N);
  localparam logic [2:0]       UnlockN = 3'(UNLOCK_N);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e     state_q;
  logic [2:0] exp_q;
  logic [2:0] run_q;
  logic [2:0] miss_q;

  logic legal, hit, run_full, miss_full, err_inc, per_inc;

  function automatic logic [2:0] succ(input logic [2:0] c);
    logic [2:0] s;
    case (c)
      3'b000:  s = 3'b011;
      3'b011:  s = 3'b101;
      3'b101:  s = 3'b110;
      3'b110:  s = 3'b010;
      3'b010:  s = 3'b001;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] code_idx(input logic [2:0] c);
    logic [2:0] i;
    case (c)
      3'b000:  i = 3'd0;
      3'b011:  i = 3'd1;
      3'b101:  i = 3'd2;
      3'b110:  i = 3'd3;
      3'b010:  i = 3'd4;
      default: i = 3'd5;
    endcase
    return i;
  endfunction

  always_comb begin
    legal     = !((bus.q == 3'b100) || (bus.q == 3'b111));
    // exp_q only ever holds legal codes, so an illegal q never hits
    hit       = (bus.q == exp_q);
    run_full  = ((run_q + 3'd1) == LockN);
    miss_full = ((miss_q + 3'd1) == UnlockN);
    err_inc   = bus.en && (state_q == StLocked) && !hit;
    // pos_q == 5 means the last legal sample was 001, so this closes a full period
    per_inc   = bus.en && (state_q == StLocked) && hit && (bus.q == 3'b000) &&
                (bus.pos == 3'd5);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSearch;
      exp_q       <= 3'b000;
      run_q       <= 3'd0;
      miss_q      <= 3'd0;
      bus.locked  <= 1'b0;
      bus.err     <= 1'b0;
      bus.illegal <= 1'b0;
      bus.pos     <= 3'd0;
      bus.err_cnt <= '0;
      bus.per_cnt <= '0;
    end else begin
      bus.err     <= 1'b0;
      bus.illegal <= 1'b0;
      if (bus.en) begin
        bus.illegal <= !legal;
        exp_q       <= legal ? succ(bus.q) : succ(exp_q);
        if (legal) begin
          bus.pos <= code_idx(bus.q);
        end
        case (state_q)
          StSearch: begin
            if (legal) begin
              state_q <= StAcquire;
              run_q   <= 3'd0;
            end
          end
          StAcquire: begin
            if (hit) begin
              run_q <= run_q + 3'd1;
              if (run_full) begin
                state_q    <= StLocked;
                bus.locked <= 1'b1;
                miss_q     <= 3'd0;
              end
            end else if (legal) begin
              run_q <= 3'd0;
            end else begin
              state_q <= StSearch;
            end
          end
          StLocked: begin
            if (hit) begin
              miss_q <= 3'd0;
            end else begin
              bus.err <= 1'b1;
              miss_q  <= miss_q + 3'd1;
              if (miss_full) begin
                state_q    <= StSearch;
                bus.locked <= 1'b0;
              end
            end
          end
          default: begin
            state_q    <= StSearch;
            bus.locked <= 1'b0;
          end
        endcase
      end
      if (bus.clr_cnt) begin
        bus.err_cnt <= '0;
        bus.per_cnt <= '0;
      end else begin
        if (err_inc && (bus.err_cnt != CntMax)) begin
          bus.err_cnt <= bus.err_cnt + 1'b1;
        end
        if (per_inc) begin
          bus.per_cnt <= bus.per_cnt + 1'b1;
        end
      end
    end
  end

endmodule
